// File: rtl/pipe_spawner.sv
// -----------------------------------------------------------------------------
// pipe_spawner
//   Turns the 5-bit LFSR word into the scrolling pipe obstacles of the game.
//   Four pipe slots (right-edge X, gap-centre Y, valid) scroll left once per
//   frame tick. A new pipe spawns after every SPACING pixels of scroll, and
//   score_pulse fires when a pipe's right edge crosses BIRD_X. All outputs are
//   registered.
//
//   Optional feature macro: PIPE_SPEEDUP_EN
//     defined   : every 8th score raises the scroll speed by 1 (up to SPEED_MAX)
//     undefined : the scroll speed is the constant SPEED
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rnd[4:0]     LFSR word, sampled on the tick that spawns
//   frame_tick   one-cycle pulse per video frame
//   run          game active level
//   clear        synchronous restart pulse (beats run and frame_tick)
//   pipe_x       4 x 11-bit right-edge X, slot k at [11k+10:11k]
//   pipe_gap_y   4 x 9-bit gap centre,   slot k at [9k+8:9k]
//   pipe_valid   slot occupied flags
//   spawn_pulse  one cycle: a pipe was spawned
//   score_pulse  one cycle: a pipe right edge crossed BIRD_X
//   dbg_state    FSM state (0 IDLE, 1 SCROLL, 2 HALT)
// -----------------------------------------------------------------------------
module pipe_spawner #(
    parameter int SCREEN_W  = 640,
    parameter int PIPE_W    = 52,
    parameter int SPACING   = 200,
    parameter int GAP_MIN   = 80,
    parameter int GAP_STEP  = 8,
    parameter int BIRD_X    = 160,
    parameter int SPEED     = 2,
    parameter int SPEED_MAX = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rnd,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        clear,
    output logic [43:0] pipe_x,
    output logic [35:0] pipe_gap_y,
    output logic [3:0]  pipe_valid,
    output logic        spawn_pulse,
    output logic        score_pulse,
    output logic [1:0]  dbg_state
);

    localparam int X_W       = 11;
    localparam int G_W       = 9;
    // Speed register is sized for the highest speed the build can reach.
    localparam int SPEED_CAP = (SPEED_MAX > SPEED) ? SPEED_MAX : SPEED;
    localparam int SPD_W     = $clog2(SPEED_CAP + 1);
    localparam int D_W       = $clog2(SPACING + SPEED_CAP + 1);

    localparam logic [X_W-1:0] SPAWN_X    = X_W'(SCREEN_W + PIPE_W);
    localparam logic [X_W-1:0] BIRD_X_V   = X_W'(BIRD_X);
    localparam logic [G_W-1:0] GAP_MIN_V  = G_W'(GAP_MIN);
    localparam logic [G_W-1:0] GAP_STEP_V = G_W'(GAP_STEP);
    localparam logic [D_W-1:0] SPACING_V  = D_W'(SPACING);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [3:0][X_W-1:0]    x_q, x_nx;
    logic [3:0][G_W-1:0]    g_q, g_nx;
    logic [3:0]             v_q, v_nx;
    logic [D_W-1:0]         dist_q, dist_nx, dist_sum;
    logic [SPD_W-1:0]       speed;
    logic                   tick_go;
    logic                   spawn_nx, score_nx;
    logic                   free_hit;
    logic [1:0]             free_idx;

    // ---------------- FSM ----------------
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (run)  state_nx = SCROLL;
                SCROLL:  if (!run) state_nx = HALT;
                HALT:    state_nx = HALT;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign tick_go = (state == SCROLL) && frame_tick && !clear;

    // ---------------- tick datapath ----------------
    always_comb begin
        x_nx     = x_q;
        g_nx     = g_q;
        v_nx     = v_q;
        dist_nx  = dist_q;
        spawn_nx = 1'b0;
        score_nx = 1'b0;
        free_hit = 1'b0;
        free_idx = 2'd0;

        // Free slot is chosen from the pre-retire flags, so a slot retired on
        // this tick only becomes reusable on the following tick.
        for (int k = 3; k >= 0; k--) begin
            if (!v_q[k]) begin
                free_hit = 1'b1;
                free_idx = 2'(k);
            end
        end

        for (int k = 0; k < 4; k++) begin
            if (v_q[k]) begin
                if (x_q[k] <= X_W'(speed)) begin
                    v_nx[k] = 1'b0;
                end else begin
                    x_nx[k] = x_q[k] - X_W'(speed);
                    if ((x_q[k] > BIRD_X_V) && (x_nx[k] <= BIRD_X_V))
                        score_nx = 1'b1;
                end
            end
        end

        dist_sum = dist_q + D_W'(speed);
        if (dist_sum >= SPACING_V) begin
            if (free_hit) begin
                spawn_nx       = 1'b1;
                dist_nx        = dist_sum - SPACING_V;
                x_nx[free_idx] = SPAWN_X;
                g_nx[free_idx] = GAP_MIN_V + G_W'(rnd) * GAP_STEP_V;
                v_nx[free_idx] = 1'b1;
            end else begin
                // Hold at the threshold so the spawn retries next tick.
                dist_nx = SPACING_V;
            end
        end else begin
            dist_nx = dist_sum;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_q         <= '0;
            g_q         <= '0;
            v_q         <= '0;
            dist_q      <= SPACING_V;
            spawn_pulse <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            spawn_pulse <= 1'b0;
            score_pulse <= 1'b0;
            if (clear) begin
                x_q    <= '0;
                g_q    <= '0;
                v_q    <= '0;
                dist_q <= SPACING_V;
            end else if (tick_go) begin
                x_q         <= x_nx;
                g_q         <= g_nx;
                v_q         <= v_nx;
                dist_q      <= dist_nx;
                spawn_pulse <= spawn_nx;
                score_pulse <= score_nx;
            end
        end
    end

`ifdef PIPE_SPEEDUP_EN
    logic [2:0] score_cnt;

    // The raised speed lands on the same edge as the 8th score pulse, so it
    // takes effect from the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed     <= SPD_W'(SPEED);
            score_cnt <= 3'd0;
        end else if (clear) begin
            speed     <= SPD_W'(SPEED);
            score_cnt <= 3'd0;
        end else if (tick_go && score_nx) begin
            score_cnt <= score_cnt + 3'd1;
            if ((score_cnt == 3'd7) && (speed < SPD_W'(SPEED_MAX)))
                speed <= speed + SPD_W'(1);
        end
    end
`else
    assign speed = SPD_W'(SPEED);
`endif

    assign pipe_x     = x_q;
    assign pipe_gap_y = g_q;
    assign pipe_valid = v_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_pipe_spawner.sv
// -----------------------------------------------------------------------------
// tb_pipe_spawner
//   Two pipe_spawner instances share one stimulus stream: dut0 uses the default
//   SPACING=200, dut1 uses SPACING=100 so its slots fill up and spawns stall.
//   A tick-level model of the game rules predicts every output; a negedge
//   process compares both instances each cycle. Directed literal checks pin
//   the model at the interesting ticks.
// -----------------------------------------------------------------------------
module tb_pipe_spawner;

  localparam int SPAWN_X  = 692;
  localparam int BIRD_X   = 160;
  localparam int GAP_MIN  = 80;
  localparam int GAP_STEP = 8;
  localparam int SPEED    = 2;
  localparam int SPD_MAX  = 6;
  localparam int M_IDLE   = 0;
  localparam int M_SCROLL = 1;
  localparam int M_HALT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  rnd;
  logic        frame_tick, run, clear;
  logic [43:0] px [2];
  logic [35:0] pg [2];
  logic [3:0]  pv [2];
  logic        sp [2];
  logic        sc [2];
  logic [1:0]  dst [2];

  pipe_spawner #(.SPACING(200)) dut0 (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .frame_tick(frame_tick), .run(run),
    .clear(clear), .pipe_x(px[0]), .pipe_gap_y(pg[0]), .pipe_valid(pv[0]),
    .spawn_pulse(sp[0]), .score_pulse(sc[0]), .dbg_state(dst[0])
  );

  pipe_spawner #(.SPACING(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .frame_tick(frame_tick), .run(run),
    .clear(clear), .pipe_x(px[1]), .pipe_gap_y(pg[1]), .pipe_valid(pv[1]),
    .spawn_pulse(sp[1]), .score_pulse(sc[1]), .dbg_state(dst[1])
  );

  int checks = 0;
  int errors = 0;
  int tick_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mx [2][4];
  int mg [2][4];
  bit mv [2][4];
  int mdist [2];
  int mspd [2];
  int mcnt [2];
  int mmode [2];
  bit esp [2];
  bit esc [2];
  int spacing [2] = '{200, 100};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        mx[i][k] = 0; mg[i][k] = 0; mv[i][k] = 0;
      end
      mdist[i] = spacing[i];
      mspd[i]  = SPEED;
      mcnt[i]  = 0;
      mmode[i] = M_IDLE;
      esp[i]   = 0;
      esc[i]   = 0;
    end
  endtask

  // One game-frame step for instance i.
  task automatic model_tick(input int i);
    int free_slot;
    int total;
    free_slot = -1;
    for (int k = 0; k < 4; k++)
      if (!mv[i][k] && free_slot < 0) free_slot = k;
    for (int k = 0; k < 4; k++) begin
      if (mv[i][k]) begin
        if (mx[i][k] <= mspd[i]) mv[i][k] = 0;
        else begin
          if (mx[i][k] > BIRD_X && mx[i][k] - mspd[i] <= BIRD_X) esc[i] = 1;
          mx[i][k] = mx[i][k] - mspd[i];
        end
      end
    end
    total = mdist[i] + mspd[i];
    if (total >= spacing[i]) begin
      if (free_slot >= 0) begin
        mx[i][free_slot] = SPAWN_X;
        mg[i][free_slot] = GAP_MIN + int'(rnd) * GAP_STEP;
        mv[i][free_slot] = 1;
        esp[i] = 1;
        mdist[i] = total - spacing[i];
      end else begin
        mdist[i] = spacing[i];
      end
    end else begin
      mdist[i] = total;
    end
`ifdef PIPE_SPEEDUP_EN
    if (esc[i]) begin
      mcnt[i]++;
      if (mcnt[i] == 8) begin
        mcnt[i] = 0;
        if (mspd[i] < SPD_MAX) mspd[i]++;
      end
    end
`endif
  endtask

  task automatic model_step(input int i);
    esp[i] = 0;
    esc[i] = 0;
    if (clear) begin
      for (int k = 0; k < 4; k++) begin
        mx[i][k] = 0; mg[i][k] = 0; mv[i][k] = 0;
      end
      mdist[i] = spacing[i];
      mspd[i]  = SPEED;
      mcnt[i]  = 0;
      mmode[i] = M_IDLE;
    end else if (mmode[i] == M_IDLE) begin
      if (run) mmode[i] = M_SCROLL;
    end else if (mmode[i] == M_SCROLL) begin
      if (frame_tick) model_tick(i);
      if (!run) mmode[i] = M_HALT;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic compare_inst(input int i);
    logic [43:0] ex;
    logic [35:0] eg;
    logic [3:0]  ev;
    for (int k = 0; k < 4; k++) begin
      ex[11*k +: 11] = 11'(mx[i][k]);
      eg[9*k +: 9]   = 9'(mg[i][k]);
      ev[k]          = mv[i][k];
    end
    check($sformatf("dut%0d pipe_valid", i), 64'(pv[i]), 64'(ev));
    check($sformatf("dut%0d pipe_x", i), 64'(px[i]), 64'(ex));
    check($sformatf("dut%0d pipe_gap_y", i), 64'(pg[i]), 64'(eg));
    check($sformatf("dut%0d spawn_pulse", i), 64'(sp[i]), 64'(esp[i]));
    check($sformatf("dut%0d score_pulse", i), 64'(sc[i]), 64'(esc[i]));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      compare_inst(0);
      compare_inst(1);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [4:0] r_of(input int t);
    return 5'((t * 11 + 3) % 32);
  endfunction

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) @(negedge clk);
  endtask

  task automatic do_tick(input logic [4:0] r);
    rnd = r;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    tick_n++;
  endtask

  task automatic run_to(input int t);
    while (tick_n < t) begin
      idle(1);
      do_tick(r_of(tick_n + 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; run = 1'b0; clear = 1'b0; frame_tick = 1'b0; rnd = 5'd0;
    idle(2);
    check("reset valid", 64'(pv[0]), 64'd0);
    check("reset x", 64'(px[0]), 64'd0);
    check("reset spawn", 64'(sp[0]), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // run rising together with a tick: nothing is processed
    run = 1'b1; frame_tick = 1'b1; rnd = 5'd3;
    @(negedge clk);
    frame_tick = 1'b0;
    check("run+tick no spawn", 64'(pv[0]), 64'd0);

    do_tick(5'd5);
    check("t1 spawn", 64'(sp[0]), 64'd1);
    check("t1 valid", 64'(pv[0]), 64'b0001);
    check("t1 x0", 64'(px[0][10:0]), 64'd692);
    check("t1 gap0", 64'(pg[0][8:0]), 64'd120);

    run_to(11);
    check("t11 x0", 64'(px[0][10:0]), 64'd672);
    run_to(100);
    check("t100 spawn", 64'(sp[0]), 64'd1);
    check("t100 valid", 64'(pv[0]), 64'b0011);
    run_to(149);
    check("d1 t149 valid", 64'(pv[1]), 64'b0111);
    run_to(150);
    check("d1 t150 valid", 64'(pv[1]), 64'b1111);
    check("d1 t150 spawn", 64'(sp[1]), 64'd1);
    run_to(266);
    check("t266 x0", 64'(px[0][10:0]), 64'd162);
    check("t266 score", 64'(sc[0]), 64'd0);
    run_to(267);
    check("t267 x0", 64'(px[0][10:0]), 64'd160);
    check("t267 score", 64'(sc[0]), 64'd1);
    run_to(346);
    check("t346 x0", 64'(px[0][10:0]), 64'd2);
    check("t346 valid", 64'(pv[0]), 64'b1111);
    run_to(347);
    check("t347 valid", 64'(pv[0]), 64'b1110);
    check("d1 t347 valid", 64'(pv[1]), 64'b1110);
    check("d1 t347 spawn", 64'(sp[1]), 64'd0);
    run_to(348);
    check("d1 t348 spawn", 64'(sp[1]), 64'd1);
    check("d1 t348 valid", 64'(pv[1]), 64'b1111);
    check("d1 t348 x0", 64'(px[1][10:0]), 64'd692);
    run_to(350);

    // halt: 50 ticks must change nothing
    run = 1'b0;
    idle(1);
    for (int j = 0; j < 50; j++) begin
      do_tick(r_of(j));
      idle(1);
    end
    check("halt x0", 64'(px[1][10:0]), 64'd688);
    check("halt valid", 64'(pv[1]), 64'b1111);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear valid0", 64'(pv[0]), 64'd0);
    check("clear valid1", 64'(pv[1]), 64'd0);
    run = 1'b1;
    idle(1);
    do_tick(5'd31);
    check("restart spawn", 64'(sp[0]), 64'd1);
    check("restart x0", 64'(px[0][10:0]), 64'd692);
    check("restart gap0 max", 64'(pg[0][8:0]), 64'd328);

    // long run: back-to-back ticks with occasional gaps
    for (int j = 0; j < 2000; j++) begin
      if (j % 7 == 6) idle(1);
      do_tick(r_of(j * 3));
    end
`ifdef PIPE_SPEEDUP_EN
    check("speed ceiling", 64'(mspd[1]), 64'(SPD_MAX));
`endif

    // asynchronous reset in the middle of a cycle, pipes in flight
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid0", 64'(pv[0]), 64'd0);
    check("async rst valid1", 64'(pv[1]), 64'd0);
    check("async rst x1", 64'(px[1]), 64'd0);
    check("async rst gap1", 64'(pg[1]), 64'd0);
    check("async rst spawn", 64'(sp[1]), 64'd0);
    check("async rst score", 64'(sc[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
